// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: 2*DW-bit dividend by DW-bit divisor,
// one quotient bit per clock, with a START/BUSY/DONE handshake.
module seq_divider #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2*DW-1:0] DIVIDEND,
    input  logic [DW-1:0]   DIVISOR,
    output logic [DW-1:0]   QUOTIENT,
    output logic [DW-1:0]   REMAINDER,
    output logic            BUSY,
    output logic            DONE,
    output logic            DIV_ZERO,
    output logic            OVERFLOW
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW:0]     p_q, p_d;
    logic [DW-1:0]   q_q, q_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   quotient_q, quotient_d;
    logic [DW-1:0]   remainder_q, remainder_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            div_zero_q, div_zero_d;
    logic            overflow_q, overflow_d;

    logic [DW:0]     t;
    logic [DW:0]     diff;
    logic            qbit;

    // The shifted partial remainder needs the full DW+1 bits: it can exceed
    // 2^DW-1 even though the stored remainder is always below the divisor.
    always_comb begin
        t    = (DW+1)'({p_q, q_q[DW-1]});
        diff = t - {1'b0, dvs_q};
        qbit = (t >= {1'b0, dvs_q});
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (START) begin
                    dvs_d      = DIVISOR;
                    p_d        = {1'b0, DIVIDEND[2*DW-1:DW]};
                    q_d        = DIVIDEND[DW-1:0];
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    overflow_d = 1'b0;
                    if (DIVISOR == '0) begin
                        div_zero_d  = 1'b1;
                        quotient_d  = '1;
                        remainder_d = DIVIDEND[DW-1:0];
                        done_d      = 1'b1;
                        state_d     = FIN;
                    end else if (DIVIDEND[2*DW-1:DW] >= DIVISOR) begin
                        overflow_d  = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '1;
                        done_d      = 1'b1;
                        state_d     = FIN;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                p_d   = qbit ? diff : t;
                q_d   = {q_q[DW-2:0], qbit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW-1)) begin
                    quotient_d  = q_d;
                    remainder_d = p_d[DW-1:0];
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            p_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign QUOTIENT  = quotient_q;
    assign REMAINDER = remainder_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign DIV_ZERO  = div_zero_q;
    assign OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, flags, handshake,
// reset abort and a sampled multiplier round trip.
module tb_seq_divider;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] DIVIDEND;
    logic [7:0]  DIVISOR;
    logic [7:0]  QUOTIENT;
    logic [7:0]  REMAINDER;
    logic        BUSY;
    logic        DONE;
    logic        DIV_ZERO;
    logic        OVERFLOW;

    int checks = 0;
    int errors = 0;

    seq_divider #(.DW(8), .CW(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .QUOTIENT  (QUOTIENT),
        .REMAINDER (REMAINDER),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DIV_ZERO  (DIV_ZERO),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Issues a one-cycle START, then waits (bounded) for DONE. lat counts edges
    // from the START edge to the cycle in which DONE is seen.
    task automatic run(input logic [15:0] dd, input logic [7:0] dv,
                       output int lat, output int bcnt);
        logic [7:0] q0;
        logic       held;
        q0   = QUOTIENT;
        held = 1'b1;
        DIVIDEND = dd;
        DIVISOR  = dv;
        START    = 1'b1;
        tick();
        START = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (DONE !== 1'b1 && lat < 20) begin
            if (BUSY === 1'b1) begin
                bcnt++;
                if (QUOTIENT !== q0) held = 1'b0;
            end
            tick();
            lat++;
        end
        check("done_seen", {15'd0, DONE}, 16'd1);
        if (bcnt > 0) check("quotient_held_in_calc", {15'd0, held}, 16'd1);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                 input logic dz, input logic ov,
                                 input int lat, input int lat_exp,
                                 input int bcnt, input int bcnt_exp);
        check({tag, "_quotient"},  {8'd0, QUOTIENT},  {8'd0, q});
        check({tag, "_remainder"}, {8'd0, REMAINDER}, {8'd0, r});
        check({tag, "_div_zero"},  {15'd0, DIV_ZERO}, {15'd0, dz});
        check({tag, "_overflow"},  {15'd0, OVERFLOW}, {15'd0, ov});
        check({tag, "_latency"},   16'(lat),  16'(lat_exp));
        check({tag, "_busy_cycles"}, 16'(bcnt), 16'(bcnt_exp));
        check({tag, "_busy_at_done"}, {15'd0, BUSY}, 16'd0);
        tick();
        check({tag, "_done_pulse"}, {15'd0, DONE}, 16'd0);
        check({tag, "_quotient_after"}, {8'd0, QUOTIENT}, {8'd0, q});
    endtask

    initial begin
        int  lat, bcnt, n;
        logic saw_done;

        RESET    = 1'b0;
        START    = 1'b0;
        DIVIDEND = '0;
        DIVISOR  = '0;
        #1;
        check("rst_quotient",  {8'd0, QUOTIENT},  16'd0);
        check("rst_remainder", {8'd0, REMAINDER}, 16'd0);
        check("rst_flags", {12'd0, BUSY, DONE, DIV_ZERO, OVERFLOW}, 16'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        run(16'd30, 8'd6, lat, bcnt);
        expect_result("inv_30_6", 8'd5, 8'd0, 1'b0, 1'b0, lat, 9, bcnt, 8);

        run(16'hFEFF, 8'hFF, lat, bcnt);
        expect_result("cmp9_feff", 8'hFF, 8'hFE, 1'b0, 1'b0, lat, 9, bcnt, 8);

        run(16'hFE01, 8'hFF, lat, bcnt);
        expect_result("cmp9_fe01", 8'hFF, 8'h00, 1'b0, 1'b0, lat, 9, bcnt, 8);

        run(16'h1234, 8'h00, lat, bcnt);
        expect_result("div0", 8'hFF, 8'h34, 1'b1, 1'b0, lat, 1, bcnt, 0);

        run(16'h1234, 8'h12, lat, bcnt);
        expect_result("ovf", 8'hFF, 8'hFF, 1'b0, 1'b1, lat, 1, bcnt, 0);

        // A valid division after an error clears both flags.
        run(16'd30, 8'd6, lat, bcnt);
        expect_result("after_ovf", 8'd5, 8'd0, 1'b0, 1'b0, lat, 9, bcnt, 8);

        // START with new operands mid-calculation must be ignored.
        DIVIDEND = 16'd100;
        DIVISOR  = 8'd7;
        START    = 1'b1;
        tick();
        START = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (DONE !== 1'b1 && lat < 20) begin
            if (BUSY === 1'b1) bcnt++;
            if (lat == 3) begin
                DIVIDEND = 16'd50;
                DIVISOR  = 8'd5;
                START    = 1'b1;
            end else begin
                START = 1'b0;
            end
            tick();
            lat++;
        end
        START = 1'b0;
        check("hs_done_seen", {15'd0, DONE}, 16'd1);
        expect_result("hs_100_7", 8'd14, 8'd2, 1'b0, 1'b0, lat, 9, bcnt, 8);

        // Reset in the middle of a division abandons it immediately.
        DIVIDEND = 16'd200;
        DIVISOR  = 8'd3;
        START    = 1'b1;
        tick();
        START = 1'b0;
        check("rst_mid_busy_before", {15'd0, BUSY}, 16'd1);
        tick();
        tick();
        RESET = 1'b0;
        #1;
        check("rst_mid_quotient",  {8'd0, QUOTIENT},  16'd0);
        check("rst_mid_remainder", {8'd0, REMAINDER}, 16'd0);
        check("rst_mid_flags", {12'd0, BUSY, DONE, DIV_ZERO, OVERFLOW}, 16'd0);
        @(negedge CLK);
        RESET = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE === 1'b1 || BUSY === 1'b1) saw_done = 1'b1;
        end
        check("rst_mid_no_done", {15'd0, saw_done}, 16'd0);

        run(16'd30, 8'd6, lat, bcnt);
        expect_result("post_rst", 8'd5, 8'd0, 1'b0, 1'b0, lat, 9, bcnt, 8);

        // START held high restarts on the first IDLE edge after FIN.
        DIVIDEND = 16'd100;
        DIVISOR  = 8'd7;
        START    = 1'b1;
        tick();
        n = 1;
        while (DONE !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("hold_first_done", {15'd0, DONE}, 16'd1);
        check("hold_first_q", {8'd0, QUOTIENT}, 16'd14);
        tick();
        check("hold_idle_busy", {15'd0, BUSY}, 16'd0);
        tick();
        check("hold_restart_busy", {15'd0, BUSY}, 16'd1);
        START = 1'b0;
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("hold_second_done", {15'd0, DONE}, 16'd1);
        check("hold_second_r", {8'd0, REMAINDER}, 16'd2);
        tick();

        // Sampled round trip: Y = A*B divided by B returns A remainder 0.
        for (int a = 0; a < 256; a += 17) begin
            for (int b = 1; b < 256; b += 17) begin
                run(16'(a * b), 8'(b), lat, bcnt);
                check("rt_quotient",  {8'd0, QUOTIENT},  16'(a));
                check("rt_remainder", {8'd0, REMAINDER}, 16'd0);
                check("rt_flags", {14'd0, DIV_ZERO, OVERFLOW}, 16'd0);
                tick();
            end
        end
        run(16'(255 * 254), 8'd254, lat, bcnt);
        check("rt_max_quotient",  {8'd0, QUOTIENT},  16'd255);
        check("rt_max_remainder", {8'd0, REMAINDER}, 16'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned divider: 16-bit dividend by 8-bit divisor, giving an 8-bit quotient and an 8-bit remainder.
- It performs the inverse of the 8x8 Dadda multiplier: for a product Y = A*B with B != 0, Y / B returns A with remainder 0.
- Sits beside the multiplier as an ALU extension unit and uses a START/BUSY/DONE handshake with the processor control path.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- DW, 8, divisor/quotient/remainder width; the dividend is 2*DW bits wide.
- CW, 4, iteration counter width; must satisfy 2^CW > DW.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- DIVIDEND  input  16  unsigned dividend; sampled at the START edge.
- DIVISOR  input  8  unsigned divisor; sampled at the START edge.
- QUOTIENT  output  8  registered quotient.
- REMAINDER  output  8  registered remainder.
- BUSY  output  1  high while a division is in progress.
- DONE  output  1  one-cycle pulse when results are valid.
- DIV_ZERO  output  1  error flag: divisor was 0.
- OVERFLOW  output  1  error flag: quotient would not fit in 8 bits.

Behaviour:
- Reset (RESET low, any state, takes effect immediately): state IDLE; QUOTIENT, REMAINDER = 0; BUSY, DONE, DIV_ZERO, OVERFLOW = 0; internal registers and counter = 0.
- An operation in progress is abandoned on reset, with no DONE.
- States:
  - IDLE: wait for START.
  - CALC: iterate.
  - FIN: present results.
- IDLE, START=1 sampled at edge E0:
  - Latch DIVIDEND and DIVISOR. Clear DIV_ZERO and OVERFLOW.
  - If DIVISOR==0: DIV_ZERO=1, QUOTIENT=8'hFF, REMAINDER=DIVIDEND[7:0], go to FIN.
  - Else if DIVIDEND[15:8] >= DIVISOR: OVERFLOW=1, QUOTIENT=8'hFF, REMAINDER=8'hFF, go to FIN.
  - Else: go to CALC with partial remainder P(9b) = {0, DIVIDEND[15:8]}, shift register Q = DIVIDEND[7:0], counter = 0. BUSY goes high after E0.
- CALC, each edge (8 edges, E1..E8):
  - T = {P[7:0], Q[7]}.
  - If T >= {0, divisor}: P = T - divisor and the new quotient bit is 1; else P = T and the bit is 0.
  - Q = {Q[6:0], bit}; counter increments.
  - The compare must use the full 9-bit T. The shifted value can exceed 255 even though P < divisor.
  - At the edge where counter==7: QUOTIENT = Q after the shift, REMAINDER = P[7:0], go to FIN.
- FIN: DONE=1 for exactly one cycle; BUSY=0. The next edge returns to IDLE.
- Latency:
  - Normal case: DONE is high in the cycle after E8, i.e. 9 cycles after the START edge.
  - Error cases: DONE is high in the cycle after E0.
- BUSY is high from after E0 until the E8 edge (CALC only).
- QUOTIENT, REMAINDER, DIV_ZERO and OVERFLOW:
  - They hold their values after DONE until the next accepted START.
  - They do not change during CALC; internal registers are separate.
- START while in CALC or FIN is ignored; the operands are not re-sampled.
- START held high continuously starts a new division on the first IDLE edge after FIN.
- An input change after E0 has no effect on the current operation.

Test Plan:
- Inverse of the multiplier test: DIVIDEND=30, DIVISOR=6, START pulse → DONE 9 cycles later; QUOTIENT=5, REMAINDER=0; flags 0; BUSY high for 8 cycles.
- 9-bit compare path: DIVIDEND=16'hFEFF, DIVISOR=8'hFF → QUOTIENT=8'hFF, REMAINDER=8'hFE. Also DIVIDEND=16'hFE01, DIVISOR=8'hFF → QUOTIENT=8'hFF, REMAINDER=0.
- Divide by zero: DIVIDEND=16'h1234, DIVISOR=0 → DONE in the cycle after the START edge; DIV_ZERO=1, QUOTIENT=8'hFF, REMAINDER=8'h34, BUSY never high.
- Overflow: DIVIDEND=16'h1234, DIVISOR=8'h12 → OVERFLOW=1, QUOTIENT=8'hFF, REMAINDER=8'hFF, DONE after 1 cycle. A following valid START clears both flags.
- Handshake and reset:
  - Start 100/7; pulse START with 50/5 at cycle 4 → ignored; result QUOTIENT=14, REMAINDER=2.
  - Then start 200/3 and drop RESET at cycle 3 → all outputs 0 immediately, no DONE, IDLE.
- Round trip with the multiplier: for all A in 0..255 and B in 1..255, feed Y = A*B → QUOTIENT=A, REMAINDER=0, no flags.
